// File: rtl/axi_lite_mc_arbiter.sv
// Round-robin arbiter funnelling N clients' single-beat read and write requests onto one
// AXI-Lite master command port; the read and write paths are independent IDLE/ISSUE/WAIT/DONE FSMs.
module axi_lite_mc_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CLIENTS = 2
) (
    input  logic                              ACLK,
    input  logic                              ARESETn,
    input  logic [NUM_CLIENTS-1:0]            C_WREQ,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] C_WADDR,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] C_WDATA,
    output logic [NUM_CLIENTS-1:0]            C_WDONE,
    output logic [NUM_CLIENTS-1:0]            C_WERR,
    input  logic [NUM_CLIENTS-1:0]            C_RREQ,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] C_RADDR,
    output logic [DATA_WIDTH-1:0]             C_RDATA,
    output logic [NUM_CLIENTS-1:0]            C_RDONE,
    output logic [NUM_CLIENTS-1:0]            C_RERR,
    output logic                              MC_WREQ,
    output logic [ADDR_WIDTH-1:0]             MC_WADDR,
    output logic [DATA_WIDTH-1:0]             MC_WDATA,
    input  logic                              MC_BACK,
    input  logic                              MC_WERROR,
    output logic                              MC_RREQ,
    output logic [ADDR_WIDTH-1:0]             MC_RADDR,
    input  logic                              MC_RACK,
    input  logic [DATA_WIDTH-1:0]             MC_RDATA,
    input  logic                              MC_RERROR
);

    localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    // Last-grant reset value: makes client 0 the first candidate after reset.
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_CLIENTS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    function automatic logic [IW-1:0] rr_pick(input logic [NUM_CLIENTS-1:0] req,
                                              input logic [IW-1:0]          last);
        logic [IW-1:0] pick;
        logic [IW-1:0] idx;
        pick = last;
        // Walk from farthest to nearest so the closest requester after 'last' wins.
        for (int k = NUM_CLIENTS; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % NUM_CLIENTS);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

    function automatic logic [NUM_CLIENTS-1:0] onehot(input logic [IW-1:0] g);
        logic [NUM_CLIENTS-1:0] oh;
        oh    = '0;
        oh[g] = 1'b1;
        return oh;
    endfunction

    // ---------------- write path ----------------
    state_t                wr_state, wr_next;
    logic [IW-1:0]         wr_gnt;
    logic [IW-1:0]         wr_pick;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  wr_err_q;

    assign wr_pick  = rr_pick(C_WREQ, wr_gnt);
    assign MC_WADDR = wr_addr_q;
    assign MC_WDATA = wr_data_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) wr_state <= ST_IDLE;
        else          wr_state <= wr_next;
    end

    always_comb begin
        wr_next = wr_state;
        MC_WREQ = 1'b0;
        C_WDONE = '0;
        C_WERR  = '0;
        case (wr_state)
            ST_IDLE:  if (|C_WREQ) wr_next = ST_ISSUE;
            ST_ISSUE: begin
                MC_WREQ = 1'b1;
                wr_next = ST_WAIT;
            end
            ST_WAIT:  if (MC_BACK) wr_next = ST_DONE;
            ST_DONE: begin
                C_WDONE = onehot(wr_gnt);
                C_WERR  = onehot(wr_gnt) & {NUM_CLIENTS{wr_err_q}};
                wr_next = ST_IDLE;
            end
            default:  wr_next = ST_IDLE;
        endcase
    end

    // The grant register doubles as the round-robin pointer.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_gnt    <= LAST_RST;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_err_q  <= 1'b0;
        end else begin
            if (wr_state == ST_IDLE && |C_WREQ) begin
                wr_gnt    <= wr_pick;
                wr_addr_q <= C_WADDR[int'(wr_pick)*ADDR_WIDTH +: ADDR_WIDTH];
                wr_data_q <= C_WDATA[int'(wr_pick)*DATA_WIDTH +: DATA_WIDTH];
            end
            if (wr_state == ST_WAIT && MC_BACK) wr_err_q <= MC_WERROR;
        end
    end

    // ---------------- read path ----------------
    state_t                rd_state, rd_next;
    logic [IW-1:0]         rd_gnt;
    logic [IW-1:0]         rd_pick;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_err_q;

    assign rd_pick  = rr_pick(C_RREQ, rd_gnt);
    assign MC_RADDR = rd_addr_q;
    assign C_RDATA  = rd_data_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) rd_state <= ST_IDLE;
        else          rd_state <= rd_next;
    end

    always_comb begin
        rd_next = rd_state;
        MC_RREQ = 1'b0;
        C_RDONE = '0;
        C_RERR  = '0;
        case (rd_state)
            ST_IDLE:  if (|C_RREQ) rd_next = ST_ISSUE;
            ST_ISSUE: begin
                MC_RREQ = 1'b1;
                rd_next = ST_WAIT;
            end
            ST_WAIT:  if (MC_RACK) rd_next = ST_DONE;
            ST_DONE: begin
                C_RDONE = onehot(rd_gnt);
                C_RERR  = onehot(rd_gnt) & {NUM_CLIENTS{rd_err_q}};
                rd_next = ST_IDLE;
            end
            default:  rd_next = ST_IDLE;
        endcase
    end

    // Read data is only overwritten by a completion, so C_RDATA stays valid between reads.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_gnt    <= LAST_RST;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            if (rd_state == ST_IDLE && |C_RREQ) begin
                rd_gnt    <= rd_pick;
                rd_addr_q <= C_RADDR[int'(rd_pick)*ADDR_WIDTH +: ADDR_WIDTH];
            end
            if (rd_state == ST_WAIT && MC_RACK) begin
                rd_data_q <= MC_RDATA;
                rd_err_q  <= MC_RERROR;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_mc_arbiter.sv
// Directed scenarios plus randomized multi-client traffic against a transaction-level
// round-robin reference model for axi_lite_mc_arbiter.
module tb_axi_lite_mc_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            ACLK;
    logic            ARESETn;
    logic [N-1:0]    C_WREQ, C_WDONE, C_WERR, C_RREQ, C_RDONE, C_RERR;
    logic [N*AW-1:0] C_WADDR, C_RADDR;
    logic [N*DW-1:0] C_WDATA;
    logic [DW-1:0]   C_RDATA;
    logic            MC_WREQ, MC_BACK, MC_WERROR, MC_RREQ, MC_RACK, MC_RERROR;
    logic [AW-1:0]   MC_WADDR, MC_RADDR;
    logic [DW-1:0]   MC_WDATA, MC_RDATA;

    int checks   = 0;
    int failures = 0;

    axi_lite_mc_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CLIENTS(N)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .C_WREQ(C_WREQ), .C_WADDR(C_WADDR), .C_WDATA(C_WDATA), .C_WDONE(C_WDONE), .C_WERR(C_WERR),
        .C_RREQ(C_RREQ), .C_RADDR(C_RADDR), .C_RDATA(C_RDATA), .C_RDONE(C_RDONE), .C_RERR(C_RERR),
        .MC_WREQ(MC_WREQ), .MC_WADDR(MC_WADDR), .MC_WDATA(MC_WDATA),
        .MC_BACK(MC_BACK), .MC_WERROR(MC_WERROR),
        .MC_RREQ(MC_RREQ), .MC_RADDR(MC_RADDR),
        .MC_RACK(MC_RACK), .MC_RDATA(MC_RDATA), .MC_RERROR(MC_RERROR)
    );

    logic [1+AW+DW+1+AW+4*N+DW-1:0] all_outs;
    assign all_outs = {MC_WREQ, MC_WADDR, MC_WDATA, MC_RREQ, MC_RADDR,
                       C_WDONE, C_WERR, C_RDONE, C_RERR, C_RDATA};

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_inputs();
        C_WREQ = '0; C_WADDR = '0; C_WDATA = '0; C_RREQ = '0; C_RADDR = '0;
        MC_BACK = 1'b0; MC_WERROR = 1'b0; MC_RACK = 1'b0; MC_RDATA = '0; MC_RERROR = 1'b0;
    endtask

    // Round-robin rule: first requester strictly after the last grant, wrapping.
    function automatic int rr_next(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++)
            if (req[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic test_reset();
        ARESETn = 1'b0;
        clear_inputs();
        C_WREQ = '1; C_RREQ = '1; MC_BACK = 1'b1; MC_RACK = 1'b1; MC_RDATA = '1;
        tick(); tick();
        checks++;
        if (all_outs !== '0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", all_outs);
        end
        clear_inputs();
        ARESETn = 1'b1;
        tick();
        checks++;
        if (all_outs !== '0) begin
            failures++; $display("FAIL idle_after_release got=%h exp=0", all_outs);
        end
    endtask

    task automatic test_single_write();
        C_WADDR[0 +: AW] = 32'h10;
        C_WDATA[0 +: DW] = 32'hA5A5A5A5;
        C_WREQ = 3'b001;
        tick();
        checks++;
        if (MC_WREQ !== 1'b1 || MC_WADDR !== 32'h10 || MC_WDATA !== 32'hA5A5A5A5) begin
            failures++; $display("FAIL wr_issue got req=%b addr=%h data=%h exp req=1 addr=10 data=a5a5a5a5",
                                 MC_WREQ, MC_WADDR, MC_WDATA);
        end
        tick();
        checks++;
        if (MC_WREQ !== 1'b0 || MC_WADDR !== 32'h10 || C_WDONE !== '0) begin
            failures++; $display("FAIL wr_wait got req=%b addr=%h done=%b exp req=0 addr=10 done=000",
                                 MC_WREQ, MC_WADDR, C_WDONE);
        end
        MC_BACK = 1'b1; MC_WERROR = 1'b0;
        tick();
        checks++;
        if (C_WDONE !== 3'b001 || C_WERR !== 3'b000) begin
            failures++; $display("FAIL wr_done got done=%b err=%b exp done=001 err=000", C_WDONE, C_WERR);
        end
        C_WREQ = '0; MC_BACK = 1'b0;
        tick();
        checks++;
        if (C_WDONE !== '0 || MC_WREQ !== 1'b0 || MC_WDATA !== 32'hA5A5A5A5) begin
            failures++; $display("FAIL wr_done_one_cycle got done=%b req=%b data=%h exp done=000 req=0 data=a5a5a5a5",
                                 C_WDONE, MC_WREQ, MC_WDATA);
        end
    endtask

    task automatic test_contention();
        C_RADDR[0*AW +: AW] = 32'h100;
        C_RADDR[1*AW +: AW] = 32'h104;
        C_RADDR[2*AW +: AW] = 32'h108;
        C_RREQ = 3'b011;
        tick();
        checks++;
        if (MC_RREQ !== 1'b1 || MC_RADDR !== 32'h100) begin
            failures++; $display("FAIL rr_first got req=%b addr=%h exp req=1 addr=100", MC_RREQ, MC_RADDR);
        end
        tick();
        MC_RACK = 1'b1; MC_RDATA = 32'h11;
        tick();
        MC_RACK = 1'b0;
        checks++;
        if (C_RDONE !== 3'b001 || C_RDATA !== 32'h11) begin
            failures++; $display("FAIL rr_done0 got done=%b data=%h exp done=001 data=11", C_RDONE, C_RDATA);
        end
        C_RREQ[0] = 1'b0;
        tick();
        C_RREQ[0] = 1'b1;
        tick();
        checks++;
        if (MC_RREQ !== 1'b1 || MC_RADDR !== 32'h104) begin
            failures++; $display("FAIL rr_rotate got req=%b addr=%h exp req=1 addr=104", MC_RREQ, MC_RADDR);
        end
        tick();
        MC_RACK = 1'b1; MC_RDATA = 32'h22;
        tick();
        MC_RACK = 1'b0;
        checks++;
        if (C_RDONE !== 3'b010 || C_RDATA !== 32'h22) begin
            failures++; $display("FAIL rr_done1 got done=%b data=%h exp done=010 data=22", C_RDONE, C_RDATA);
        end
        C_RREQ[1] = 1'b0;
        tick(); tick();
        checks++;
        if (MC_RREQ !== 1'b1 || MC_RADDR !== 32'h100) begin
            failures++; $display("FAIL rr_wrap got req=%b addr=%h exp req=1 addr=100", MC_RREQ, MC_RADDR);
        end
        tick();
        MC_RACK = 1'b1; MC_RDATA = 32'h33;
        tick();
        MC_RACK = 1'b0;
        C_RREQ = '0;
        tick();
    endtask

    task automatic test_concurrent();
        C_WADDR[1*AW +: AW] = 32'h20;
        C_WDATA[1*DW +: DW] = 32'h1234;
        C_RADDR[0*AW +: AW] = 32'h30;
        C_WREQ = 3'b010; C_RREQ = 3'b001;
        tick();
        checks++;
        if (MC_WREQ !== 1'b1 || MC_RREQ !== 1'b1 || MC_WADDR !== 32'h20 ||
            MC_WDATA !== 32'h1234 || MC_RADDR !== 32'h30) begin
            failures++; $display("FAIL conc_issue got wreq=%b rreq=%b waddr=%h wdata=%h raddr=%h exp 1 1 20 1234 30",
                                 MC_WREQ, MC_RREQ, MC_WADDR, MC_WDATA, MC_RADDR);
        end
        tick();
        MC_RACK = 1'b1; MC_RDATA = 32'hCAFE;
        tick();
        checks++;
        if (C_RDONE !== 3'b001 || C_WDONE !== 3'b000) begin
            failures++; $display("FAIL conc_rdone got rdone=%b wdone=%b exp rdone=001 wdone=000", C_RDONE, C_WDONE);
        end
        C_RREQ = '0; MC_RACK = 1'b0;
        MC_BACK = 1'b1; MC_WERROR = 1'b1;
        tick();
        checks++;
        if (C_WDONE !== 3'b010 || C_WERR !== 3'b010 || C_RDONE !== 3'b000) begin
            failures++; $display("FAIL conc_wdone got wdone=%b werr=%b rdone=%b exp 010 010 000",
                                 C_WDONE, C_WERR, C_RDONE);
        end
        C_WREQ = '0; MC_BACK = 1'b0; MC_WERROR = 1'b0;
        tick();
    endtask

    task automatic test_read_error();
        C_RADDR[2*AW +: AW] = 32'h200;
        C_RREQ = 3'b100;
        tick(); tick();
        MC_RACK = 1'b1; MC_RDATA = 32'hDEADBEEF; MC_RERROR = 1'b1;
        tick();
        checks++;
        if (C_RDONE !== 3'b100 || C_RERR !== 3'b100 || C_RDATA !== 32'hDEADBEEF) begin
            failures++; $display("FAIL rd_error got done=%b err=%b data=%h exp 100 100 deadbeef",
                                 C_RDONE, C_RERR, C_RDATA);
        end
        C_RREQ = '0; MC_RACK = 1'b0; MC_RERROR = 1'b0; MC_RDATA = 32'h55;
        tick(); tick();
        checks++;
        if (C_RDATA !== 32'hDEADBEEF || C_RERR !== '0 || C_RDONE !== '0) begin
            failures++; $display("FAIL rd_hold got data=%h err=%b done=%b exp deadbeef 000 000",
                                 C_RDATA, C_RERR, C_RDONE);
        end
    endtask

    task automatic test_reset_during_wait();
        C_WADDR[1*AW +: AW] = 32'h40;
        C_RADDR[1*AW +: AW] = 32'h44;
        C_WREQ = 3'b010; C_RREQ = 3'b010;
        tick();
        checks++;
        if (MC_WREQ !== 1'b1 || MC_RREQ !== 1'b1 || MC_WADDR !== 32'h40 || MC_RADDR !== 32'h44) begin
            failures++; $display("FAIL rst_pre_issue got %b %b %h %h exp 1 1 40 44",
                                 MC_WREQ, MC_RREQ, MC_WADDR, MC_RADDR);
        end
        tick();
        MC_BACK = 1'b1; MC_RACK = 1'b1;
        ARESETn = 1'b0;
        #1;
        checks++;
        if (all_outs !== '0) begin
            failures++; $display("FAIL rst_async_clear got=%h exp=0", all_outs);
        end
        tick();
        checks++;
        if (all_outs !== '0) begin
            failures++; $display("FAIL rst_no_done got=%h exp=0", all_outs);
        end
        MC_BACK = 1'b0; MC_RACK = 1'b0;
        C_WADDR[0*AW +: AW] = 32'h50; C_WADDR[2*AW +: AW] = 32'h58;
        C_RADDR[0*AW +: AW] = 32'h54; C_RADDR[2*AW +: AW] = 32'h5C;
        C_WREQ = '1; C_RREQ = '1;
        ARESETn = 1'b1;
        tick();
        checks++;
        if (MC_WREQ !== 1'b1 || MC_RREQ !== 1'b1 || MC_WADDR !== 32'h50 || MC_RADDR !== 32'h54 ||
            C_WDONE !== '0 || C_RDONE !== '0) begin
            failures++; $display("FAIL rst_restart got %b %b %h %h %b %b exp 1 1 50 54 000 000",
                                 MC_WREQ, MC_RREQ, MC_WADDR, MC_RADDR, C_WDONE, C_RDONE);
        end
        clear_inputs();
        tick();
    endtask

    // Path 0 = write, path 1 = read. Each path is modelled as: a grant happens whenever the
    // path is free and someone requests; completion is seen one cycle after the master acks.
    task automatic test_random_traffic(input int cycles);
        logic [N-1:0]  req [2];
        logic [N-1:0]  waiting [2];
        logic [N-1:0]  fresh [2];
        logic [AW-1:0] addr [2][N];
        logic [DW-1:0] wdat [N];
        int            last [2], gnt [2], free_at [2], ack_cnt [2];
        bit            busy [2], exp_done [2], exp_err [2];
        logic [AW-1:0] exp_maddr [2];
        logic [DW-1:0] exp_mdata, exp_rdata, rd_val;
        logic [N-1:0]  obs_done, obs_err, exp_oh;
        logic          obs_issue;
        int            g;
        bit            addr_bad;

        clear_inputs();
        ARESETn = 1'b0;
        tick();
        ARESETn = 1'b1;
        exp_mdata = '0; exp_rdata = '0; rd_val = '0;
        for (int p = 0; p < 2; p++) begin
            req[p] = '0; waiting[p] = '0; last[p] = N - 1; gnt[p] = 0; free_at[p] = 0;
            ack_cnt[p] = 0; busy[p] = 0; exp_done[p] = 0; exp_err[p] = 0; exp_maddr[p] = '0;
            for (int i = 0; i < N; i++) addr[p][i] = '0;
        end
        for (int i = 0; i < N; i++) wdat[i] = '0;

        for (int t = 0; t < cycles; t++) begin
            tick();
            MC_BACK = 1'b0; MC_RACK = 1'b0; MC_WERROR = 1'b0; MC_RERROR = 1'b0;
            MC_RDATA = $urandom;
            for (int p = 0; p < 2; p++) begin
                fresh[p]  = '0;
                obs_issue = (p == 0) ? MC_WREQ : MC_RREQ;
                obs_done  = (p == 0) ? C_WDONE : C_RDONE;
                obs_err   = (p == 0) ? C_WERR  : C_RERR;
                exp_oh = '0;
                if (exp_done[p]) exp_oh[gnt[p]] = 1'b1;
                checks++;
                if (obs_done !== exp_oh || obs_err !== (exp_err[p] ? exp_oh : '0)) begin
                    failures++; $display("FAIL rnd_done path=%0d t=%0d got done=%b err=%b exp done=%b err=%b",
                                         p, t, obs_done, obs_err, exp_oh, exp_err[p] ? exp_oh : '0);
                end
                if (exp_done[p]) begin
                    busy[p] = 0; exp_done[p] = 0; free_at[p] = t + 2;
                    waiting[p][gnt[p]] = 1'b0; req[p][gnt[p]] = 1'b0; fresh[p][gnt[p]] = 1'b1;
                    if (p == 1) exp_rdata = rd_val;
                end

                if (!busy[p] && t >= free_at[p] && |req[p]) begin
                    g = rr_next(req[p], last[p]);
                    checks++;
                    if (obs_issue !== 1'b1) begin
                        failures++; $display("FAIL rnd_missing_issue path=%0d t=%0d got=%b exp=1", p, t, obs_issue);
                    end
                    busy[p] = 1; gnt[p] = g; last[p] = g; waiting[p][g] = 1'b1;
                    ack_cnt[p] = $urandom_range(1, 4);
                    exp_maddr[p] = addr[p][g];
                    if (p == 0) exp_mdata = wdat[g];
                end else begin
                    checks++;
                    if (obs_issue !== 1'b0) begin
                        failures++; $display("FAIL rnd_extra_issue path=%0d t=%0d got=%b exp=0", p, t, obs_issue);
                    end
                    if (busy[p]) begin
                        ack_cnt[p]--;
                        if (ack_cnt[p] == 0) begin
                            exp_done[p] = 1;
                            exp_err[p]  = ($urandom_range(0, 1) == 1);
                            if (p == 0) begin
                                MC_BACK = 1'b1; MC_WERROR = exp_err[p];
                            end else begin
                                rd_val = $urandom;
                                MC_RACK = 1'b1; MC_RDATA = rd_val; MC_RERROR = exp_err[p];
                            end
                        end
                    end
                end

                addr_bad = (p == 0) ? (MC_WADDR !== exp_maddr[0] || MC_WDATA !== exp_mdata)
                                    : (MC_RADDR !== exp_maddr[1]);
                checks++;
                if (addr_bad) begin
                    failures++; $display("FAIL rnd_cmd_hold path=%0d t=%0d got waddr=%h wdata=%h raddr=%h exp addr=%h wdata=%h",
                                         p, t, MC_WADDR, MC_WDATA, MC_RADDR, exp_maddr[p], exp_mdata);
                end
            end
            checks++;
            if (C_RDATA !== exp_rdata) begin
                failures++; $display("FAIL rnd_rdata t=%0d got=%h exp=%h", t, C_RDATA, exp_rdata);
            end

            // Client behaviour: idle clients start requests at random; a granted client may
            // abandon its request early but waits for its done before asking again.
            for (int p = 0; p < 2; p++) begin
                for (int i = 0; i < N; i++) begin
                    if (!req[p][i] && !waiting[p][i] && !fresh[p][i]) begin
                        if ($urandom_range(0, 3) == 0) begin
                            req[p][i]  = 1'b1;
                            addr[p][i] = $urandom;
                            if (p == 0) wdat[i] = $urandom;
                        end
                    end else if (req[p][i] && waiting[p][i] && $urandom_range(0, 7) == 0) begin
                        req[p][i] = 1'b0;
                    end
                end
            end
            C_WREQ = req[0];
            C_RREQ = req[1];
            for (int i = 0; i < N; i++) begin
                C_WADDR[i*AW +: AW] = addr[0][i];
                C_WDATA[i*DW +: DW] = wdat[i];
                C_RADDR[i*AW +: AW] = addr[1][i];
            end
        end
        clear_inputs();
    endtask

    initial begin
        ARESETn = 1'b0;
        clear_inputs();
        test_reset();
        test_single_write();
        test_contention();
        test_concurrent();
        test_read_error();
        test_reset_during_wait();
        test_random_traffic(3000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
